// File: rtl/vecvec_operand_loader.sv
// -----------------------------------------------------------------------------
// vecvec_operand_loader
//
// Upstream feeder for the fixed-point dot-product unit (vecvec<N>).
//
// Vector elements arrive one at a time on a valid/ready stream: all
// VECTOR_SIZE elements of A first, then all elements of B. They are assembled
// into the flat vec_a / vec_b buses. Once both vectors are loaded, the loader
// releases the dot unit's active-high restart (dot_rst) and waits for its
// complete flag. The result is then captured and offered on a valid/ready
// output. A watchdog abandons the run if the dot unit never completes.
//
// Element i of each vector sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
// No arithmetic is done here. BIN_POS is only carried along for the dot unit,
// and the result is passed through bit-exact.
//
// Parameters
//   DATA_WIDTH   element/result width (two's-complement fixed point)
//   BIN_POS      binary point position (pass-through only)
//   VECTOR_SIZE  elements per vector (>= 1)
//   TIMEOUT      max RUN cycles to wait for dot_complete (>= 2)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   in_valid      in   in_data holds an element
//   in_ready      out  loader accepts an element this cycle (LOAD_A/LOAD_B)
//   in_data       in   element, A elements first, then B elements
//   vec_a         out  assembled A vector
//   vec_b         out  assembled B vector
//   dot_rst       out  active-high restart to the dot unit, low only in RUN
//   dot_complete  in   dot unit result valid
//   dot_result    in   dot unit result
//   out_valid     out  out_dot holds a result
//   out_ready     in   consumer accepts the result
//   out_dot       out  captured dot result
//   busy          out  state is RUN or HOLD
//   timeout       out  sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module vecvec_operand_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int VECTOR_SIZE = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_a,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_b,
    output logic                              dot_rst,
    input  logic                              dot_complete,
    input  logic [DATA_WIDTH-1:0]             dot_result,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_dot,
    output logic                              busy,
    output logic                              timeout
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    // A single-element vector still needs a 1-bit slot index.
    localparam int IDX_W  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(VECTOR_SIZE - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    // Reject parameter sets the datapath cannot represent.
    if (VECTOR_SIZE < 1 || TIMEOUT < 2 || BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_bad_params
        $error("vecvec_operand_loader: illegal VECTOR_SIZE/TIMEOUT/BIN_POS");
    end

    // -------------------------------------------------------------------------
    // State machine encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDX_W-1:0]  idx;
    logic [WDOG_W-1:0] wdog;

    logic loading;        // LOAD_A or LOAD_B
    logic accept;         // element transferred on this edge
    logic last_elem;      // accepted element fills the final slot
    logic wdog_expired;   // RUN has lasted TIMEOUT cycles without completion
    logic out_fire;       // result handshake on this edge

    assign loading      = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign accept       = in_valid && loading;
    assign last_elem    = accept && (idx == IDX_LAST);
    assign wdog_expired = (wdog == WDOG_LAST);
    assign out_fire     = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state is defaulted before the case so that no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                next_state = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                if (last_elem) next_state = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                if (last_elem) next_state = ST_RUN;
            end
            ST_RUN: begin
                // A completion on the final watchdog cycle still wins.
                if (dot_complete) begin
                    next_state = ST_HOLD;
                end else if (wdog_expired) begin
                    next_state = ST_LOAD_A;
                end
            end
            ST_HOLD: begin
                if (out_fire) next_state = ST_LOAD_A;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state)
            ST_LOAD_A, ST_LOAD_B: in_ready = 1'b1;
            ST_RUN, ST_HOLD:      busy     = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand assembly
    // -------------------------------------------------------------------------
    // Only the addressed slot is written. Slots not yet rewritten in the
    // current load keep the previous vector's values.
    // NOTE: the operand registers are flops, not a RAM, so they can be cleared
    // by reset. This makes the buses read zero right after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            vec_a <= '0;
            vec_b <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < VECTOR_SIZE; i++) begin
                    if (idx == IDX_W'(i)) begin
                        if (state == ST_LOAD_A) begin
                            vec_a[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        end else begin
                            vec_b[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        end
                    end
                end
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else if (state == ST_RUN && !dot_complete && wdog_expired) begin
                // An abandoned run restarts loading from slot 0.
                idx <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    // Cleared in every state except RUN, so each run starts counting from 0.
    // The count reaches TIMEOUT-1 on the TIMEOUT-th RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog <= '0;
        end else if (state == ST_RUN) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Result capture and output handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_dot   <= '0;
            out_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (dot_complete) begin
                        out_dot   <= dot_result;
                        out_valid <= 1'b1;
                    end else if (wdog_expired) begin
                        timeout <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // out_dot stays frozen until the next capture.
                    if (out_fire) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Dot unit restart
    // -------------------------------------------------------------------------
    // Registered from next_state. dot_rst therefore drops on the same edge that
    // enters RUN and rises on the edge that leaves it. It stays high through
    // the whole load, at least 2*VECTOR_SIZE cycles before every run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dot_rst <= 1'b1;
        end else begin
            dot_rst <= (next_state != ST_RUN);
        end
    end

endmodule
